// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback self-test.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_RX,
    WAIT_IDLE,
    FINISH
  } bist_state_t;

  // Feedback taps of the pattern LFSR: bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // An all-zero LFSR state would lock up, so a zero seed becomes this value.
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

  localparam int TIMEOUT_CYCLES_DEF = 200000;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/uart_loopback_bist_if.sv
// Handshake between the self-test sequencer and the UART loopback top.
interface uart_loopback_bist_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_done;

  // The sequencer drives the transmit request and watches the UART status.
  modport master (output tx_start, tx_data, input tx_busy, rx_data, rx_done);
  // The UART side answers the request.
  modport slave  (input tx_start, tx_data, output tx_busy, rx_data, rx_done);
endinterface

// File: rtl/uart_pattern_gen.sv
// Expected-byte generator: incrementing or LFSR sequence from a seed.
module uart_pattern_gen
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  input  logic       mode,
  input  logic [7:0] seed,
  output logic [7:0] expected
);

  logic mode_reg;

  // Latch mode and first byte on load; step the sequence on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg <= 1'b0;
      expected <= 8'h00;
    end else if (load) begin
      mode_reg <= mode;
      expected <= (mode && seed == 8'h00) ? LFSR_ZERO_SUB : seed;
    end else if (advance) begin
      expected <= mode_reg ? lfsr_next(expected) : expected + 8'd1;
    end
  end

endmodule

// File: rtl/uart_loopback_bist.sv
// Loopback self-test sequencer: sends pattern bytes, checks echoes,
// counts mismatches and timeouts, reports pass/fail.
module uart_loopback_bist
  import uart_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int ERR_W          = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [7:0]              seed,
  input  logic [CNT_W-1:0]        num_bytes,
  uart_loopback_bist_if.master    uart,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERR_W-1:0]        err_count,
  output logic [CNT_W-1:0]        sent_count
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  bist_state_t      state_reg, state_next;
  logic [TMR_W-1:0] timer_reg;
  logic [CNT_W-1:0] num_reg;
  logic [7:0]       expected;

  logic tmr_expired;
  logic load_pat, adv_pat, err_inc, to_set, sent_inc, run_start, run_end;

  assign tmr_expired   = (timer_reg >= TMR_LAST);
  // Decoded straight from the state so reset drops the pulse immediately.
  assign uart.tx_start = (state_reg == SEND);
  assign uart.tx_data  = expected;

  uart_pattern_gen u_pattern (
    .clk      (clk),
    .rst      (rst),
    .load     (load_pat),
    .advance  (adv_pat),
    .mode     (mode),
    .seed     (seed),
    .expected (expected)
  );

  // Next-state and per-cycle event decode.
  always_comb begin
    state_next = state_reg;
    load_pat   = 1'b0;
    adv_pat    = 1'b0;
    err_inc    = 1'b0;
    to_set     = 1'b0;
    sent_inc   = 1'b0;
    run_start  = 1'b0;
    run_end    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          run_start  = 1'b1;
          load_pat   = 1'b1;
          state_next = (num_bytes == '0) ? FINISH : SEND;
        end
      end
      SEND: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart.tx_busy) begin
          state_next = WAIT_RX;
        end else if (tmr_expired) begin
          to_set     = 1'b1;
          err_inc    = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_RX: begin
        // A byte arriving on the expiry cycle still counts as received.
        if (uart.rx_done) begin
          err_inc    = (uart.rx_data != expected);
          state_next = WAIT_IDLE;
        end else if (tmr_expired) begin
          to_set     = 1'b1;
          err_inc    = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // rx_done lands inside the stop bit, so wait for the transmitter.
        if (!uart.tx_busy || tmr_expired) begin
          to_set     = uart.tx_busy;
          sent_inc   = 1'b1;
          adv_pat    = 1'b1;
          state_next = (sent_count + CNT_W'(1) == num_reg) ? FINISH : SEND;
        end
      end
      FINISH: begin
        run_end    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, per-byte timer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      num_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      sent_count <= '0;
    end else begin
      state_reg <= state_next;
      // Timer restarts on every state change except into WAIT_RX, so it spans
      // tx_start to rx_done across WAIT_BUSY and WAIT_RX.
      if (state_next != state_reg && state_next != WAIT_RX)
        timer_reg <= '0;
      else if (!tmr_expired)
        timer_reg <= timer_reg + TMR_W'(1);

      if (run_start) begin
        num_reg    <= num_bytes;
        busy       <= 1'b1;
        done       <= 1'b0;
        pass       <= 1'b0;
        timeout    <= 1'b0;
        err_count  <= '0;
        sent_count <= '0;
      end else begin
        if (err_inc && err_count != {ERR_W{1'b1}})
          err_count <= err_count + ERR_W'(1);
        if (to_set)
          timeout <= 1'b1;
        if (sent_inc)
          sent_count <= sent_count + CNT_W'(1);
        if (run_end) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0) && !timeout;
        end
      end
    end
  end

endmodule
